mips_fetch_unit: RTL

// - Instruction-side bus initiator feeding mips_control_unit: owns the PC, issues Avalon-style word reads,

---
 rtl/mips_fetch_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
// Instruction-side Avalon-MM read initiator. Owns the fetch PC, keeps at most
// one read in flight, buffers returned words with their PC in a small FIFO and
// hands {instr_word, instr_pc} to decode with a valid/ready handshake.
// Redirects from execute flush the buffer and restart fetch at the target; a
// redirect to HALT_ADDR stops fetching until reset.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target sets sticky fetch_error and halts.
//   undefined : fetch_error is tied low and target bits [1:0] are forced to 0.
// -----------------------------------------------------------------------------
module mips_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
    parameter int          DEPTH        = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_word,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        active,
    output logic        fetch_error
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ,
        S_RESP,
        S_FULL,
        S_HALT
    } state_t;

    state_t        state;
    logic [31:0]   pc;

    // Instruction buffer storage and bookkeeping
    logic [31:0]   buf_word [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [31:0]   last_word;
    logic [31:0]   last_pc;

    logic          redirect_take;
    logic          target_bad;
    logic          halt_take;
    logic [31:0]   target;
    logic          push;
    logic          pop;

    // A redirect is honoured everywhere except once halted.
    assign redirect_take = redirect_valid && (state != S_HALT);

`ifdef FETCH_ALIGN_CHECK_EN
    assign target     = redirect_target;
    assign target_bad = (redirect_target[1:0] != 2'b00);
`else
    assign target     = redirect_target & 32'hFFFF_FFFC;
    assign target_bad = 1'b0;
`endif

    assign halt_take = redirect_take && (target_bad || (target == HALT_ADDR));

    // The response word is captured in S_RESP unless a redirect makes it stale;
    // a redirect also suppresses a same-cycle pop since the buffer is flushed.
    assign push = (state == S_RESP) && !redirect_take;
    assign pop  = instr_valid && instr_ready && !redirect_take;

    assign avm_address    = pc;
    assign avm_byteenable = 4'b1111;

    assign instr_valid = (count != '0);
    assign instr_word  = instr_valid ? buf_word[rd_ptr] : last_word;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]   : last_pc;

    // Occupancy after this edge; used by the FSM to decide whether another
    // read may be launched (the launched word will need a slot on return).
    always_comb begin
        // NOTE: assign a default first so every path drives count_next; a
        // missing branch in always_comb would otherwise infer a latch.
        count_next = count;
        if (redirect_take) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    // Buffer pointers, occupancy and the held-when-empty output values.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_word <= 32'h0;
            last_pc   <= 32'h0;
        end else if (redirect_take) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_word <= buf_word[rd_ptr];
                last_pc   <= buf_pc[rd_ptr];
            end
            count <= count_next;
        end
    end

    // Buffer storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy alone
        // decides which entries are meaningful, and unreset arrays map to RAM.
        if (push && !reset) begin
            buf_word[wr_ptr] <= avm_readdata;
            buf_pc[wr_ptr]   <= pc - 32'd4;
        end
    end

    // Fetch sequencer: request, response capture, buffer-full wait and halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            avm_read <= 1'b0;
            pc       <= RESET_VECTOR;
            active   <= 1'b1;
        end else if (redirect_take) begin
            // Any stalled request is withdrawn; a request accepted this very
            // cycle returns next cycle while in S_REQ and is simply ignored.
            avm_read <= 1'b0;
            pc       <= target;
            if (halt_take) begin
                state  <= S_HALT;
                active <= 1'b0;
            end else begin
                state  <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (!avm_read) begin
                        avm_read <= 1'b1;
                    end else if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        pc       <= pc + 32'd4;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (count_next < DEPTH_C) begin
                        avm_read <= 1'b1;
                        state    <= S_REQ;
                    end else begin
                        state    <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        avm_read <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                default: begin
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_error <= 1'b0;
        end else if (redirect_take && target_bad) begin
            fetch_error <= 1'b1;
        end
    end
`else
    assign fetch_error = 1'b0;
`endif

endmodule
